// File: rtl/jtframe_multi_wait_pkg.sv
// Shared defaults and counter-sizing helper for the CPU clock-enable wait gater.
// Imported by jtframe_multi_wait and jtframe_wait_recover.
package jtframe_multi_wait_pkg;

    localparam int unsigned DEF_MISSW   = 4;
    localparam int unsigned DEF_RECGAP  = 2;
    localparam int unsigned DEF_TIMEOUT = 255;

    // Bits needed to hold 0..maxval, never less than one.
    function automatic int unsigned cnt_width(input int unsigned maxval);
        int unsigned w;
        w = 1;
        if (maxval > 1) begin
            w = $clog2(maxval + 1);
        end
        return w;
    endfunction

endpackage

// File: rtl/jtframe_wait_recover.sv
// Lost clock-enable bookkeeping: counts gated pulses and replays them as recovery pulses
// while the CPU bus is idle, keeping RECGAP cycles after any delivered pulse.
module jtframe_wait_recover
    import jtframe_multi_wait_pkg::*;
#(
    parameter int unsigned MISSW   = DEF_MISSW,
    parameter bit          RECOVER = 1'b1,
    parameter int unsigned RECGAP  = DEF_RECGAP
) (
    input  logic             rst_n,
    input  logic             clk,
    input  logic             cen_in,
    input  logic             gate,
    input  logic             rec_en,
    output logic             rec,
    output logic [MISSW-1:0] miss_cnt
);

    localparam int unsigned      GAPW     = cnt_width(RECGAP);
    localparam logic [GAPW-1:0]  GAP_LOAD = GAPW'(RECGAP);
    localparam logic [MISSW-1:0] MISS_MAX = '1;

    logic [MISSW-1:0] miss_q, miss_d;
    logic [GAPW-1:0]  gap_q, gap_d;
    logic             lost;
    logic             cen_set;

    always_comb begin
        lost    = cen_in & ~gate;
        rec     = RECOVER && (miss_q != '0) && !cen_in && rec_en && gate && (gap_q == '0);
        cen_set = (cen_in & gate) | rec;

        // lost needs ~gate while rec needs gate, so both never fire together
        miss_d = miss_q;
        if (lost && (miss_q != MISS_MAX)) begin
            miss_d = miss_q + MISSW'(1);
        end else if (rec) begin
            miss_d = miss_q - MISSW'(1);
        end

        gap_d = gap_q;
        if (cen_set) begin
            gap_d = GAP_LOAD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - GAPW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_q <= '0;
            gap_q  <= '0;
        end else begin
            miss_q <= miss_d;
            gap_q  <= gap_d;
        end
    end

    assign miss_cnt = miss_q;

endmodule

// File: rtl/jtframe_multi_wait.sv
// CPU clock-enable gater: holds the CPU while a selected ROM slot is not ready or a shared
// device is busy, replays the lost pulses later and flags long stalls.
module jtframe_multi_wait
    import jtframe_multi_wait_pkg::*;
#(
    parameter int unsigned NROM    = 2,
    parameter int unsigned DEVCNT  = 2,
    parameter int unsigned MISSW   = DEF_MISSW,
    parameter bit          RECOVER = 1'b1,
    parameter int unsigned RECGAP  = DEF_RECGAP,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              rst_n,
    input  logic              clk,
    input  logic              cen_in,
    output logic              cen_out,
    output logic              gate,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              busak_n,
    input  logic [DEVCNT-1:0] dev_busy,
    input  logic [NROM-1:0]   rom_cs,
    input  logic [NROM-1:0]   rom_ok,
    input  logic              clr_err,
    output logic [MISSW-1:0]  miss_cnt,
    output logic              stall_err
);

    localparam int unsigned    STW        = cnt_width(TIMEOUT);
    localparam logic [STW-1:0] STALL_MAX  = '1;
    localparam logic [STW-1:0] STALL_LAST = (TIMEOUT == 0) ? '0 : STW'(TIMEOUT - 1);

    logic [NROM-1:0] last_cs_q, cs_rise;
    logic            locked_q, locked_d;
    logic            cen_out_q, cen_out_d;
    logic [STW-1:0]  stall_cnt_q, stall_cnt_d;
    logic            stall_err_q, stall_err_d;
    logic            rom_bad, dev_any, rec_en, rec, lost, stall_set;

    always_comb begin
        // A fresh select has stale data even if rom_ok is still high from the last access
        cs_rise   = rom_cs & ~last_cs_q;
        rom_bad   = (|(rom_cs & ~rom_ok)) | (|cs_rise);
        dev_any   = |dev_busy;
        locked_d  = rom_bad | dev_any;
        gate      = ~(rom_bad | dev_any | locked_q);
        rec_en    = mreq_n & iorq_n & busak_n;
        lost      = cen_in & ~gate;
        cen_out_d = (cen_in & gate) | rec;

        stall_cnt_d = stall_cnt_q;
        if (cen_in && gate) begin
            stall_cnt_d = '0;
        end else if (lost && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + STW'(1);
        end

        // Fires only on the step onto TIMEOUT, so a saturated count lets clr_err stick
        stall_set   = (TIMEOUT != 0) && lost && (stall_cnt_q == STALL_LAST);
        stall_err_d = stall_err_q;
        if (stall_set) begin
            stall_err_d = 1'b1;
        end else if (clr_err) begin
            stall_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_cs_q   <= '1;
            locked_q    <= 1'b0;
            cen_out_q   <= 1'b0;
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            last_cs_q   <= rom_cs;
            locked_q    <= locked_d;
            cen_out_q   <= cen_out_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    jtframe_wait_recover #(
        .MISSW   (MISSW),
        .RECOVER (RECOVER),
        .RECGAP  (RECGAP)
    ) u_recover (
        .rst_n    (rst_n),
        .clk      (clk),
        .cen_in   (cen_in),
        .gate     (gate),
        .rec_en   (rec_en),
        .rec      (rec),
        .miss_cnt (miss_cnt)
    );

    assign cen_out   = cen_out_q;
    assign stall_err = stall_err_q;

endmodule

// File: tb/tb_jtframe_multi_wait.sv
// Directed bench for jtframe_multi_wait: cycle tables for ROM wait and bus-idle recovery,
// hand-written sequences for saturation, stall timeout and mid-stall reset.
module tb_jtframe_multi_wait;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cen_in, cen_out, gate;
    logic       mreq_n, iorq_n, busak_n, clr_err, stall_err;
    logic [1:0] dev_busy, rom_cs, rom_ok;
    logic [3:0] miss_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       cen;
        logic [1:0] cs;
        logic [1:0] ok;
        logic [1:0] busy;
        logic       mreq_n;
        logic       gate;
        logic       co;
        logic [3:0] miss;
    } vec_t;

    vec_t t2[21];
    vec_t t3[15];

    jtframe_multi_wait #(
        .NROM    (2),
        .DEVCNT  (2),
        .MISSW   (4),
        .RECOVER (1'b1),
        .RECGAP  (2),
        .TIMEOUT (8)
    ) dut (
        .rst_n     (rst_n),
        .clk       (clk),
        .cen_in    (cen_in),
        .cen_out   (cen_out),
        .gate      (gate),
        .mreq_n    (mreq_n),
        .iorq_n    (iorq_n),
        .busak_n   (busak_n),
        .dev_busy  (dev_busy),
        .rom_cs    (rom_cs),
        .rom_ok    (rom_ok),
        .clr_err   (clr_err),
        .miss_cnt  (miss_cnt),
        .stall_err (stall_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t v(input logic cen, input logic [1:0] cs, input logic [1:0] ok,
                               input logic [1:0] busy, input logic mq, input logic g,
                               input logic co, input logic [3:0] miss);
        vec_t r;
        r.cen = cen; r.cs = cs; r.ok = ok; r.busy = busy; r.mreq_n = mq;
        r.gate = g; r.co = co; r.miss = miss;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t x, input string tag, input int idx);
        cen_in   = x.cen;
        rom_cs   = x.cs;
        rom_ok   = x.ok;
        dev_busy = x.busy;
        mreq_n   = x.mreq_n;
        @(negedge clk);
        check($sformatf("%s[%0d].gate", tag, idx), {31'd0, gate}, {31'd0, x.gate});
        tick();
        check($sformatf("%s[%0d].cen_out", tag, idx), {31'd0, cen_out}, {31'd0, x.co});
        check($sformatf("%s[%0d].miss", tag, idx), {28'd0, miss_cnt}, {28'd0, x.miss});
    endtask

    initial begin
        int pulses;

        // ROM channel 1 selected, data late for 10 clk, cen_in every 4 clk from c1
        t2[0]  = v(1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 4'd0);
        t2[1]  = v(1'b1, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 4'd1);
        t2[2]  = v(1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 4'd1);
        t2[3]  = v(1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 4'd1);
        t2[4]  = v(1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 4'd1);
        t2[5]  = v(1'b1, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 4'd2);
        t2[6]  = v(1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 4'd2);
        t2[7]  = v(1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 4'd2);
        t2[8]  = v(1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 4'd2);
        t2[9]  = v(1'b1, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 4'd3);
        t2[10] = v(1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 4'd3);
        t2[11] = v(1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 4'd2);
        t2[12] = v(1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 4'd2);
        t2[13] = v(1'b1, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 4'd2);
        t2[14] = v(1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 4'd2);
        t2[15] = v(1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 4'd2);
        t2[16] = v(1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 4'd1);
        t2[17] = v(1'b1, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 4'd1);
        t2[18] = v(1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 4'd1);
        t2[19] = v(1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 4'd1);
        t2[20] = v(1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 4'd0);

        // Busy device makes 2 misses; recovery blocked while mreq_n low
        t3[0]  = v(1'b0, 2'b10, 2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 4'd0);
        t3[1]  = v(1'b1, 2'b10, 2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 4'd1);
        t3[2]  = v(1'b0, 2'b10, 2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 4'd1);
        t3[3]  = v(1'b1, 2'b10, 2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 4'd2);
        t3[4]  = v(1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 4'd2);
        t3[5]  = v(1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 4'd2);
        t3[6]  = v(1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 4'd2);
        t3[7]  = v(1'b1, 2'b10, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 4'd2);
        t3[8]  = v(1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 4'd2);
        t3[9]  = v(1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 4'd2);
        t3[10] = v(1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 4'd1);
        t3[11] = v(1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 4'd1);
        t3[12] = v(1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 4'd1);
        t3[13] = v(1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 4'd0);
        t3[14] = v(1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 4'd0);

        rst_n = 1'b0; cen_in = 1'b0; mreq_n = 1'b1; iorq_n = 1'b1; busak_n = 1'b1;
        dev_busy = 2'b00; rom_cs = 2'b00; rom_ok = 2'b11; clr_err = 1'b0;
        repeat (3) tick();
        check("reset.cen_out", {31'd0, cen_out}, 32'd0);
        check("reset.miss", {28'd0, miss_cnt}, 32'd0);
        check("reset.stall_err", {31'd0, stall_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset.gate", {31'd0, gate}, 32'd1);
        tick();

        // 1: free running, cen_out is cen_in one clk later
        for (int i = 0; i < 16; i++) begin
            cen_in = (i % 4 == 1);
            tick();
            check($sformatf("t1[%0d].cen_out", i), {31'd0, cen_out}, {31'd0, (i % 4 == 1)});
            check($sformatf("t1[%0d].miss", i), {28'd0, miss_cnt}, 32'd0);
        end

        // 2 and 3: tables
        for (int i = 0; i < 21; i++) run_vec(t2[i], "t2", i);
        for (int i = 0; i < 15; i++) run_vec(t3[i], "t3", i);

        // 4: 100 gated pulses saturate the miss counter; exactly 15 replays follow
        dev_busy = 2'b01;
        for (int i = 0; i < 100; i++) begin
            cen_in = 1'b1; tick();
            cen_in = 1'b0; tick();
        end
        check("t4.miss_sat", {28'd0, miss_cnt}, 32'd15);
        check("t4.stall_err", {31'd0, stall_err}, 32'd1);
        @(negedge clk);
        check("t4.gate_low", {31'd0, gate}, 32'd0);
        tick();
        dev_busy = 2'b00;
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (cen_out) pulses++;
        end
        check("t4.rec_pulses", pulses, 32'd15);
        check("t4.miss_drained", {28'd0, miss_cnt}, 32'd0);

        // 5: stall watchdog at TIMEOUT=8
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("t5.clr_initial", {31'd0, stall_err}, 32'd0);
        cen_in = 1'b1; tick(); cen_in = 1'b0;
        check("t5.pass_pulse", {31'd0, cen_out}, 32'd1);
        tick();
        dev_busy = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            cen_in = 1'b1; tick();
            if (k == 7) check("t5.err_after_7", {31'd0, stall_err}, 32'd0);
            if (k == 8) check("t5.err_after_8", {31'd0, stall_err}, 32'd1);
            cen_in = 1'b0; tick();
        end
        dev_busy = 2'b00;
        repeat (5) tick();
        check("t5.err_sticky", {31'd0, stall_err}, 32'd1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("t5.err_cleared", {31'd0, stall_err}, 32'd0);
        repeat (40) tick();
        check("t5.miss_drained", {28'd0, miss_cnt}, 32'd0);

        // 6: reset in the middle of a stall drops pending recovery
        rom_cs = 2'b11; rom_ok = 2'b11; dev_busy = 2'b01;
        for (int i = 0; i < 5; i++) begin
            cen_in = 1'b1; tick();
            cen_in = 1'b0; tick();
        end
        check("t6.miss_before", {28'd0, miss_cnt}, 32'd5);
        #2 rst_n = 1'b0;
        #1;
        check("t6.miss_async", {28'd0, miss_cnt}, 32'd0);
        check("t6.cen_out_async", {31'd0, cen_out}, 32'd0);
        check("t6.err_async", {31'd0, stall_err}, 32'd0);
        tick();
        dev_busy = 2'b00;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t6.gate_cs_held", {31'd0, gate}, 32'd1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cen_out) pulses++;
        end
        check("t6.no_recovery", pulses, 32'd0);
        check("t6.miss_after", {28'd0, miss_cnt}, 32'd0);
        cen_in = 1'b1; tick(); cen_in = 1'b0;
        check("t6.pulse_passes", {31'd0, cen_out}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
